// File: rtl/npc_pkg.sv
// Shared NPC core types: access sizes, LSU controller states and
// byte-lane helpers used by the load/store path.
package npc_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Byte enables for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the doubleword offset is not a multiple of the access size.
  function automatic logic addr_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatting: shift the addressed lane down, truncate to the
// access size and sign- or zero-extend to the full beat width.
module lsu_load_ext
  import npc_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] beat,
  input  logic [2:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted_s;

  // Lane select followed by size truncation and extension.
  always_comb begin
    shifted_s = beat >> {off, 3'b000};
    case (size)
      SZ_B:    data = {{(DATA_W-8){shifted_s[7]  & ~is_unsigned}}, shifted_s[7:0]};
      SZ_H:    data = {{(DATA_W-16){shifted_s[15] & ~is_unsigned}}, shifted_s[15:0]};
      SZ_W:    data = {{(DATA_W-32){shifted_s[31] & ~is_unsigned}}, shifted_s[31:0]};
      SZ_D:    data = shifted_s;
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu_pmem_ctrl.sv
// Single-outstanding load/store controller driving the DPI pmem port.
// All outputs are registered; wmask is nonzero only during the WR cycle.
module lsu_pmem_ctrl
  import npc_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RD   = RD;
  localparam logic [1:0] ST_WR   = WR;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state_r;
  logic [2:0]        off_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic              resp_err_r;
  logic [ADDR_W-1:0] mem_raddr_r;
  logic [ADDR_W-1:0] mem_waddr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [MASK_W-1:0] mem_wmask_r;
  logic [DATA_W-1:0] load_data_s;
  logic              misaligned_s;

  assign misaligned_s = addr_misaligned(req_addr[2:0], req_size);

  lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .beat        (mem_rdata),
    .off         (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .data        (load_data_s)
  );

  // Controller FSM; port values for the next access cycle are set up on entry
  // so the mem_* outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      off_r        <= 3'd0;
      size_r       <= 2'd0;
      uns_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
      mem_raddr_r  <= '0;
      mem_waddr_r  <= '0;
      mem_wdata_r  <= '0;
      mem_wmask_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            off_r       <= req_addr[2:0];
            size_r      <= req_size;
            uns_r       <= req_unsigned;
            req_ready_r <= 1'b0;
            if (misaligned_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= '0;
            end else if (req_wen) begin
              state_r     <= ST_WR;
              mem_waddr_r <= {req_addr[ADDR_W-1:3], 3'b000};
              mem_wdata_r <= req_wdata << {req_addr[2:0], 3'b000};
              mem_wmask_r <= size_mask(req_size) << req_addr[2:0];
            end else begin
              state_r     <= ST_RD;
              mem_raddr_r <= {req_addr[ADDR_W-1:3], 3'b000};
            end
          end
        end
        ST_RD: begin
          state_r      <= ST_RESP;
          mem_raddr_r  <= '0;
          resp_rdata_r <= load_data_s;
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
        end
        ST_WR: begin
          state_r      <= ST_RESP;
          mem_waddr_r  <= '0;
          mem_wdata_r  <= '0;
          mem_wmask_r  <= '0;
          resp_rdata_r <= '0;
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          mem_raddr_r  <= '0;
          mem_waddr_r  <= '0;
          mem_wdata_r  <= '0;
          mem_wmask_r  <= '0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_raddr  = mem_raddr_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wmask  = mem_wmask_r;

endmodule
